// File: rtl/sw_conditioner_pkg.sv
// Shared types, constants and helpers for the switch conditioner.
package sw_cond_pkg;

    // Per-channel debounce FSM state encoding.
    typedef logic [0:0] deb_state_t;

    localparam deb_state_t STABLE = 1'b0;
    localparam deb_state_t CHECK  = 1'b1;

    // 10 ms of qualification at a 50 MHz system clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 500000;

    // Counter width: ceil(log2(cycles)), never below one bit. The counter
    // only has to reach cycles-1, so this is the narrowest width that holds it.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(cycles)) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/sw_conditioner_if.sv
// Switch conditioner signal bundle: raw levels in, debounced levels and
// edge pulses out.
interface sw_conditioner_if #(
    parameter int N_CH = 3
);

    logic [N_CH-1:0] sw_raw;
    logic [N_CH-1:0] sw_external_connection_export;
    logic [N_CH-1:0] sw_rise;
    logic [N_CH-1:0] sw_fall;
    logic            sw_changed;

    // Board / consumer side: drives raw levels, observes conditioned outputs.
    modport master (
        output sw_raw,
        input  sw_external_connection_export,
        input  sw_rise,
        input  sw_fall,
        input  sw_changed
    );

    // Conditioner side.
    modport slave (
        input  sw_raw,
        output sw_external_connection_export,
        output sw_rise,
        output sw_fall,
        output sw_changed
    );

endinterface

// File: rtl/sw_conditioner_debounce_ch.sv
// One switch channel: two-flop synchronizer, debounce FSM with qualification
// counter, registered level output and registered rise/fall pulses.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   STABLE | sample matches accepted level; counter parked at 0
//   CHECK  | sample differs from accepted level; counting consecutive
//          | differing samples, any reversion returns to STABLE at 0
//
// The accepted level (stable_q) updates DEBOUNCE_CYCLES cycles after the
// sample first differs. The output level and pulses are one more register
// stage, so the level and its pulse appear together, DEBOUNCE_CYCLES+2
// cycles after a raw edge. rise_d/fall_d are exposed so the top can register
// its combined change flag on the same edge as the pulses.
module sw_debounce_ch
    import sw_cond_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sw_raw,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic rise_d_o,
    output logic fall_d_o
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    deb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stable_q, stable_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    // Synchronizer next values: raw -> sync1 -> sync2 (the sample).
    always_comb begin
        sync1_d = sw_raw;
        sync2_d = sync1_q;
    end

    // Debounce FSM and qualification counter; the counter tops out at
    // DEBOUNCE_CYCLES-1 and is cleared on every exit from CHECK.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        case (state_q)
            STABLE: begin
                cnt_d = '0;
                if (sync2_q != stable_q) begin
                    state_d = CHECK;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK: begin
                if (sync2_q == stable_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_TC) begin
                    state_d  = STABLE;
                    cnt_d    = '0;
                    stable_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output stage: level follows the accepted level one cycle later, and
    // the pulses mark the cycle in which the two disagree.
    always_comb begin
        level_d = stable_q;
        rise_d  = stable_q & ~level_q;
        fall_d  = ~stable_q & level_q;
    end

    // State registers with synchronous reset to the configured idle level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= RESET_LEVEL;
            sync2_q  <= RESET_LEVEL;
            state_q  <= STABLE;
            cnt_q    <= '0;
            stable_q <= RESET_LEVEL;
            level_q  <= RESET_LEVEL;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            level_q  <= level_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign level_o  = level_q;
    assign rise_o   = rise_q;
    assign fall_o   = fall_q;
    assign rise_d_o = rise_d;
    assign fall_d_o = fall_d;

endmodule

// File: rtl/sw_conditioner.sv
// Multi-channel switch conditioner: N_CH independent debounce channels and a
// registered any-edge flag aligned with the per-channel pulses.
module sw_conditioner
    import sw_cond_pkg::*;
#(
    parameter int unsigned     N_CH            = 3,
    parameter int unsigned     DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic [N_CH-1:0] RESET_LEVEL     = '0
) (
    input  logic             clk_clk,
    input  logic             reset_reset,
    sw_conditioner_if.slave  sw_if
);

    logic [N_CH-1:0] rise_next;
    logic [N_CH-1:0] fall_next;
    logic            sw_changed_q, sw_changed_d;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        sw_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_LEVEL     (RESET_LEVEL[i])
        ) u_ch (
            .clk      (clk_clk),
            .rst      (reset_reset),
            .sw_raw   (sw_if.sw_raw[i]),
            .level_o  (sw_if.sw_external_connection_export[i]),
            .rise_o   (sw_if.sw_rise[i]),
            .fall_o   (sw_if.sw_fall[i]),
            .rise_d_o (rise_next[i]),
            .fall_d_o (fall_next[i])
        );
    end

    // Any-edge flag built from the pulses' next values so it lands with them.
    always_comb begin
        sw_changed_d = |(rise_next | fall_next);
    end

    // Registered any-edge flag.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sw_changed_q <= 1'b0;
        end else begin
            sw_changed_q <= sw_changed_d;
        end
    end

    assign sw_if.sw_changed = sw_changed_q;

endmodule

// File: tb/tb_sw_conditioner.sv
// Bench for sw_conditioner: a DEBOUNCE_CYCLES=8 instance driven from a vector
// table plus hand-written bounce/reset sequences, and a DEBOUNCE_CYCLES=2
// instance for the minimum-parameter case. Expected pulses are queued when
// stimulus is driven and matched when the DUT pulses.
module tb_sw_conditioner;

    localparam int D_A = 8;
    localparam int D_B = 2;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sw_conditioner_if #(.N_CH(3)) if_a ();
    sw_conditioner_if #(.N_CH(3)) if_b ();

    sw_conditioner #(.N_CH(3), .DEBOUNCE_CYCLES(D_A), .RESET_LEVEL(3'b000)) dut_a (
        .clk_clk     (clk),
        .reset_reset (rst_a),
        .sw_if       (if_a)
    );

    sw_conditioner #(.N_CH(3), .DEBOUNCE_CYCLES(D_B), .RESET_LEVEL(3'b000)) dut_b (
        .clk_clk     (clk),
        .reset_reset (rst_b),
        .sw_if       (if_b)
    );

    typedef struct {
        int       cyc;
        logic [2:0] rise;
        logic [2:0] fall;
        logic [2:0] level;
    } ev_t;

    typedef struct {
        logic [2:0] raw;
        int         hold;
        logic       pulse;
        logic [2:0] rise;
        logic [2:0] fall;
        logic [2:0] level_after;
    } vec_t;

    ev_t  q_a[$];
    ev_t  q_b[$];
    logic [2:0] lvl_a = 3'b000;
    logic [2:0] lvl_b = 3'b000;
    int   checks = 0;
    int   failures = 0;
    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected pulse lands D+2 edges after the first edge that samples the
    // new raw level, i.e. observed at cyc = drive cyc + D + 3.
    task automatic expect_a(input logic [2:0] rise, input logic [2:0] fall);
        ev_t e;
        lvl_a = (lvl_a | rise) & ~fall;
        e = '{cyc + D_A + 3, rise, fall, lvl_a};
        q_a.push_back(e);
    endtask

    task automatic expect_b(input logic [2:0] rise, input logic [2:0] fall);
        ev_t e;
        lvl_b = (lvl_b | rise) & ~fall;
        e = '{cyc + D_B + 3, rise, fall, lvl_b};
        q_b.push_back(e);
    endtask

    always @(negedge clk) begin : mon_a
        ev_t e;
        if ((|if_a.sw_rise) || (|if_a.sw_fall) || if_a.sw_changed) begin
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL a_unexpected_pulse: rise=%b fall=%b changed=%b, none expected (cyc %0d)",
                         if_a.sw_rise, if_a.sw_fall, if_a.sw_changed, cyc);
            end else begin
                e = q_a.pop_front();
                chk("a_pulse_cycle", cyc, e.cyc);
                chk("a_rise", {29'd0, if_a.sw_rise}, {29'd0, e.rise});
                chk("a_fall", {29'd0, if_a.sw_fall}, {29'd0, e.fall});
                chk("a_level_at_pulse", {29'd0, if_a.sw_external_connection_export}, {29'd0, e.level});
                chk("a_changed", {31'd0, if_a.sw_changed}, 32'd1);
            end
        end else if (q_a.size() > 0 && q_a[0].cyc < cyc) begin
            e = q_a.pop_front();
            checks++;
            failures++;
            $display("FAIL a_missed_pulse: no pulse by cyc %0d, required rise=%b fall=%b at cyc %0d",
                     cyc, e.rise, e.fall, e.cyc);
        end
    end

    always @(negedge clk) begin : mon_b
        ev_t e;
        if ((|if_b.sw_rise) || (|if_b.sw_fall) || if_b.sw_changed) begin
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL b_unexpected_pulse: rise=%b fall=%b changed=%b, none expected (cyc %0d)",
                         if_b.sw_rise, if_b.sw_fall, if_b.sw_changed, cyc);
            end else begin
                e = q_b.pop_front();
                chk("b_pulse_cycle", cyc, e.cyc);
                chk("b_rise", {29'd0, if_b.sw_rise}, {29'd0, e.rise});
                chk("b_fall", {29'd0, if_b.sw_fall}, {29'd0, e.fall});
                chk("b_level_at_pulse", {29'd0, if_b.sw_external_connection_export}, {29'd0, e.level});
                chk("b_changed", {31'd0, if_b.sw_changed}, 32'd1);
            end
        end else if (q_b.size() > 0 && q_b[0].cyc < cyc) begin
            e = q_b.pop_front();
            checks++;
            failures++;
            $display("FAIL b_missed_pulse: no pulse by cyc %0d, required rise=%b fall=%b at cyc %0d",
                     cyc, e.rise, e.fall, e.cyc);
        end
    end

    initial begin
        //            raw     hold pulse rise    fall    level_after
        vecs[0]  = '{3'b001, 14, 1'b1, 3'b001, 3'b000, 3'b001};  // clean edge
        vecs[1]  = '{3'b000, 14, 1'b1, 3'b000, 3'b001, 3'b000};
        vecs[2]  = '{3'b111, 14, 1'b1, 3'b111, 3'b000, 3'b111};  // simultaneous rise
        vecs[3]  = '{3'b010, 14, 1'b1, 3'b000, 3'b101, 3'b010};  // simultaneous fall
        vecs[4]  = '{3'b010, 20, 1'b0, 3'b000, 3'b000, 3'b010};  // steady, silent
        vecs[5]  = '{3'b011, 14, 1'b1, 3'b001, 3'b000, 3'b011};
        vecs[6]  = '{3'b000, 14, 1'b1, 3'b000, 3'b011, 3'b000};
        vecs[7]  = '{3'b100,  7, 1'b0, 3'b000, 3'b000, 3'b000};  // 7-cycle glitch
        vecs[8]  = '{3'b000, 14, 1'b0, 3'b000, 3'b000, 3'b000};
        vecs[9]  = '{3'b100,  8, 1'b1, 3'b100, 3'b000, 3'b000};  // 8 cycles just qualifies
        vecs[10] = '{3'b000, 14, 1'b1, 3'b000, 3'b100, 3'b000};

        rst_a = 1'b1;
        rst_b = 1'b1;
        if_a.sw_raw = 3'b000;
        if_b.sw_raw = 3'b000;
        repeat (3) @(negedge clk);
        chk("a_reset_export", {29'd0, if_a.sw_external_connection_export}, 32'd0);
        chk("a_reset_pulses", {26'd0, if_a.sw_rise, if_a.sw_fall}, 32'd0);
        chk("a_reset_changed", {31'd0, if_a.sw_changed}, 32'd0);
        chk("b_reset_export", {29'd0, if_b.sw_external_connection_export}, 32'd0);
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            if_a.sw_raw = vecs[i].raw;
            if (vecs[i].pulse) expect_a(vecs[i].rise, vecs[i].fall);
            repeat (vecs[i].hold) @(negedge clk);
            chk($sformatf("a_vec%0d_level", i),
                {29'd0, if_a.sw_external_connection_export}, {29'd0, vecs[i].level_after});
        end

        // Bounce on channel 1: 13 toggles 3 cycles apart, ending high.
        for (int k = 0; k < 13; k++) begin
            if_a.sw_raw[1] = ~if_a.sw_raw[1];
            if (k < 12) repeat (3) @(negedge clk);
        end
        expect_a(3'b010, 3'b000);
        repeat (14) @(negedge clk);
        chk("a_bounce_level", {29'd0, if_a.sw_external_connection_export}, 32'd2);
        if_a.sw_raw = 3'b000;
        expect_a(3'b000, 3'b010);
        repeat (14) @(negedge clk);

        // Reset 5 cycles into a qualification, raw left high.
        if_a.sw_raw = 3'b001;
        repeat (5) @(negedge clk);
        rst_a = 1'b1;
        @(negedge clk);
        chk("a_midreset_export", {29'd0, if_a.sw_external_connection_export}, 32'd0);
        chk("a_midreset_pulses", {26'd0, if_a.sw_rise, if_a.sw_fall}, 32'd0);
        chk("a_midreset_changed", {31'd0, if_a.sw_changed}, 32'd0);
        rst_a = 1'b0;
        expect_a(3'b001, 3'b000);
        repeat (14) @(negedge clk);
        chk("a_after_reset_level", {29'd0, if_a.sw_external_connection_export}, 32'd1);
        if_a.sw_raw = 3'b000;
        expect_a(3'b000, 3'b001);
        repeat (14) @(negedge clk);

        // Minimum qualification length: 2-cycle pulse accepted, 1-cycle not.
        if_b.sw_raw = 3'b001;
        expect_b(3'b001, 3'b000);
        repeat (2) @(negedge clk);
        if_b.sw_raw = 3'b000;
        expect_b(3'b000, 3'b001);
        repeat (3) @(negedge clk);
        chk("b_min_pulse_level", {29'd0, if_b.sw_external_connection_export}, 32'd1);
        repeat (8) @(negedge clk);
        chk("b_min_pulse_released", {29'd0, if_b.sw_external_connection_export}, 32'd0);
        if_b.sw_raw = 3'b001;
        @(negedge clk);
        if_b.sw_raw = 3'b000;
        repeat (3) @(negedge clk);
        chk("b_short_pulse_level", {29'd0, if_b.sw_external_connection_export}, 32'd0);
        repeat (8) @(negedge clk);

        chk("a_queue_drained", q_a.size(), 32'd0);
        chk("b_queue_drained", q_b.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sw_conditioner.md
SW_CONDITIONER -- requirements
Module: sw_conditioner

Interface
REQ-001 Parameter N_CH, default 3: number of switch channels; legal range 1..8.
REQ-002 Parameter DEBOUNCE_CYCLES, default 500000 (10 ms at 50 MHz): consecutive stable samples needed to accept a new level; legal range 2..2^24.
REQ-003 Parameter RESET_LEVEL, default 0 (N_CH bits): level of every channel's synchronizer and stable register after reset.
REQ-004 clk_clk  in  1  single system clock; all logic is on its rising edge.
REQ-005 reset_reset  in  1  reset; synchronous and active-high.
REQ-006 sw_raw  in  N_CH  asynchronous, bouncing board switch levels.
REQ-007 sw_external_connection_export  out  N_CH  debounced level per channel; drives the system's sw_external_connection_export input.
REQ-008 sw_rise  out  N_CH  one-cycle pulse when the matching debounced bit goes 0->1.
REQ-009 sw_fall  out  N_CH  one-cycle pulse when the matching debounced bit goes 1->0.
REQ-010 sw_changed  out  1  OR of all sw_rise and sw_fall bits, registered in the same cycle as those bits.

Function
REQ-011 Each sw_raw bit shall pass through a two-flop synchronizer; the second flop's output is the sample s.
REQ-012 Each channel shall run a two-state FSM:
- STABLE: counter = 0; if s != stable, go to CHECK and set counter = 1.
- CHECK: if s == stable, go to STABLE with counter = 0 (abort, no pulse); else if counter == DEBOUNCE_CYCLES-1, set stable = s, counter = 0, go to STABLE and pulse; else increment counter.
REQ-013 The debounced bit shall update exactly DEBOUNCE_CYCLES cycles after the first cycle in which s differs from stable, provided s does not revert in between.
REQ-014 End-to-end latency from a sw_raw edge (set up to a clock edge) to the export bit changing shall be DEBOUNCE_CYCLES+2 cycles.
REQ-015 sw_rise[i] and sw_fall[i] shall be registered and shall assert in the same cycle the export bit shows its new value, for exactly one cycle.
REQ-016 sw_rise[i] and sw_fall[i] shall never assert together.
REQ-017 Any reversion of s during CHECK shall restart qualification from zero; a partial count shall never carry over.
REQ-018 The counter shall be ceil(log2(DEBOUNCE_CYCLES)) bits wide and shall never wrap; it is bounded by DEBOUNCE_CYCLES-1.
REQ-019 Channels shall be fully independent; simultaneous qualifying changes on several channels shall each pulse in their own bit in the same cycle, and sw_changed shall assert once for that cycle.
REQ-020 With a steady sw_raw, the outputs shall hold indefinitely with no pulses.

Reset
REQ-021 While reset_reset is high at a clock edge, the following shall be loaded:
- synchronizer flops and stable registers = RESET_LEVEL;
- export = RESET_LEVEL;
- counters = 0, FSM = STABLE;
- sw_rise, sw_fall and sw_changed = 0.
REQ-022 A reset asserted mid-CHECK shall discard the count and produce no pulse.
REQ-023 After reset release, a sw_raw level different from RESET_LEVEL shall be qualified normally: pulse at DEBOUNCE_CYCLES+2 cycles.

Structure
REQ-024 Shared package sw_cond_pkg shall hold:
- the FSM state typedef (STABLE, CHECK);
- the default DEBOUNCE_CYCLES constant;
- a counter-width function.
REQ-025 Per-channel logic (synchronizer, FSM, counter, edge pulses) shall be one sub-module, sw_debounce_ch, instantiated N_CH times by generate.
REQ-026 The top level shall contain only the generate loop and the sw_changed OR-reduction register.

Verification (DEBOUNCE_CYCLES=8, N_CH=3, RESET_LEVEL=0)
REQ-027 Clean edge: sw_raw 000->001 held -> export=001 and sw_rise=001 for one cycle, 10 cycles after the edge; sw_changed=1 that cycle only.
REQ-028 Bounce: sw_raw[1] toggles every 3 cycles for 40 cycles, then holds 1 -> no pulse during bouncing; export[1]=1 and sw_rise[1] pulse 10 cycles after the last toggle.
REQ-029 Glitch: a 7-cycle high pulse on sw_raw[2] -> export, sw_rise and sw_fall stay 0.
REQ-030 Reset mid-count: reset_reset asserted 5 cycles after the sw_raw[0] edge -> all outputs 0 with no pulse; with sw_raw[0] still 1, the rise pulse arrives 10 cycles after reset release.
REQ-031 Simultaneous: sw_raw 000->111 then later 111->010 ->
- sw_rise=111 in one cycle;
- later, sw_fall=101 in one cycle with export=010;
- sw_changed one cycle each time.
REQ-032 Minimum parameter: DEBOUNCE_CYCLES=2, 2-cycle high pulse on sw_raw[0] -> export[0]=1 four cycles after the edge; a 1-cycle pulse is rejected.
